// File: rtl/board_seed_loader.sv
// Fills the Game-of-Life board RAM row by row from a serial random-bit stream.
// Each cell is the AND of DENSITY consecutive stream bits; the first cell lands at bit COLS-1.
module board_seed_loader #(
    parameter int COLS    = 32,
    parameter int ROWS    = 24,
    parameter int ADDR_W  = 5,
    parameter int DENSITY = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    output logic              random_en,
    input  logic              random_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [COLS-1:0]   wr_data,
    output logic              busy,
    output logic              done
);

    localparam int CELL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int BIT_W  = (DENSITY > 1) ? $clog2(DENSITY) : 1;
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);
    localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(COLS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DENSITY - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] row_cnt;
    logic [CELL_W-1:0] cell_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              zero_seen;
    logic [COLS-1:0]   row_reg;
    logic              cell_val;
    logic              cell_end;
    logic              row_end;

    // zero_seen records any 0 among the cell's bits so far, so the AND needs no preset.
    always_comb begin
        cell_val = ~zero_seen & random_data;
        cell_end = (bit_cnt == LAST_BIT);
        row_end  = cell_end && (cell_cnt == LAST_CELL);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        random_en = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = SHIFT;
            end
            SHIFT: begin
                random_en = 1'b1;
                if (row_end) state_nx = WRITE;
            end
            WRITE: begin
                wr_en    = 1'b1;
                state_nx = (row_cnt == LAST_ROW) ? DONE : SHIFT;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            row_cnt   <= '0;
            cell_cnt  <= '0;
            bit_cnt   <= '0;
            zero_seen <= 1'b0;
            row_reg   <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        row_cnt   <= '0;
                        cell_cnt  <= '0;
                        bit_cnt   <= '0;
                        zero_seen <= 1'b0;
                        row_reg   <= '0;
                    end
                end
                SHIFT: begin
                    if (cell_end) begin
                        bit_cnt   <= '0;
                        zero_seen <= 1'b0;
                        row_reg   <= {row_reg[COLS-2:0], cell_val};
                        if (row_end) begin
                            cell_cnt <= '0;
                            wr_addr  <= row_cnt;
                            wr_data  <= {row_reg[COLS-2:0], cell_val};
                        end else begin
                            cell_cnt <= cell_cnt + 1'b1;
                        end
                    end else begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        zero_seen <= zero_seen | ~random_data;
                    end
                end
                WRITE: begin
                    if (row_cnt != LAST_ROW) row_cnt <= row_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_seed_loader.sv
// Directed bench for board_seed_loader: three parameterisations fed from bench-owned bit streams,
// writes checked against a scoreboard of rows computed from those streams.
module tb_board_seed_loader;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // DUT a: COLS=4 ROWS=2 ADDR_W=1 DENSITY=1
    logic       start_a = 1'b0, random_data_a = 1'b0;
    logic       random_en_a, wr_en_a, busy_a, done_a;
    logic [0:0] wr_addr_a;
    logic [3:0] wr_data_a;
    // DUT b: COLS=4 ROWS=2 ADDR_W=1 DENSITY=2
    logic       start_b = 1'b0, random_data_b = 1'b0;
    logic       random_en_b, wr_en_b, busy_b, done_b;
    logic [0:0] wr_addr_b;
    logic [3:0] wr_data_b;
    // DUT c: default parameters
    logic        start_c = 1'b0, random_data_c = 1'b0;
    logic        random_en_c, wr_en_c, busy_c, done_c;
    logic [4:0]  wr_addr_c;
    logic [31:0] wr_data_c;

    board_seed_loader #(.COLS(4), .ROWS(2), .ADDR_W(1), .DENSITY(1)) dut_a (
        .clk(clk), .rst_b(rst_b), .start(start_a), .random_en(random_en_a),
        .random_data(random_data_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .busy(busy_a), .done(done_a)
    );

    board_seed_loader #(.COLS(4), .ROWS(2), .ADDR_W(1), .DENSITY(2)) dut_b (
        .clk(clk), .rst_b(rst_b), .start(start_b), .random_en(random_en_b),
        .random_data(random_data_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .busy(busy_b), .done(done_b)
    );

    board_seed_loader dut_c (
        .clk(clk), .rst_b(rst_b), .start(start_c), .random_en(random_en_c),
        .random_data(random_data_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
        .wr_data(wr_data_c), .busy(busy_c), .done(done_c)
    );

    bit  src_a[$], src_b[$], src_c[$];
    wr_t exp_a[$], exp_b[$], exp_c[$];
    int unsigned wr_cnt_a = 0, done_cnt_a = 0, ren_cnt_a = 0;
    int unsigned wr_cnt_b = 0, ren_cnt_b = 0;
    int unsigned wr_cnt_c = 0, ren_cnt_c = 0, ones_c = 0;
    logic en_a_q, en_b_q, en_c_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_row(input bit b[$], input int unsigned base,
                                              input int unsigned cols, input int unsigned d);
        logic [31:0] r;
        logic        v;
        r = '0;
        for (int unsigned c = 0; c < cols; c++) begin
            v = 1'b1;
            for (int unsigned j = 0; j < d; j++) v = v & b[base + c * d + j];
            r = {r[30:0], v};
        end
        return r;
    endfunction

    // Stream source: a bit presented during a cycle with random_en high is consumed at that edge.
    always @(posedge clk) begin
        en_a_q = random_en_a;
        en_b_q = random_en_b;
        en_c_q = random_en_c;
        #1;
        if (en_a_q && src_a.size() > 0) void'(src_a.pop_front());
        if (en_b_q && src_b.size() > 0) void'(src_b.pop_front());
        if (en_c_q && src_c.size() > 0) void'(src_c.pop_front());
        random_data_a = (src_a.size() > 0) ? src_a[0] : 1'b0;
        random_data_b = (src_b.size() > 0) ? src_b[0] : 1'b0;
        random_data_c = (src_c.size() > 0) ? src_c[0] : 1'b0;
    end

    always @(negedge clk) begin
        wr_t e;
        if (wr_en_a) begin
            wr_cnt_a++;
            if (exp_a.size() == 0) check("a_unexpected_write", 64'(wr_addr_a), 64'hFFFF);
            else begin
                e = exp_a.pop_front();
                check("a_wr_addr", 64'(wr_addr_a), 64'(e.addr));
                check("a_wr_data", 64'(wr_data_a), 64'(e.data));
            end
        end
        if (random_en_a) ren_cnt_a++;
        if (done_a) done_cnt_a++;
        if (wr_en_b) begin
            wr_cnt_b++;
            if (exp_b.size() == 0) check("b_unexpected_write", 64'(wr_addr_b), 64'hFFFF);
            else begin
                e = exp_b.pop_front();
                check("b_wr_addr", 64'(wr_addr_b), 64'(e.addr));
                check("b_wr_data", 64'(wr_data_b), 64'(e.data));
            end
        end
        if (random_en_b) ren_cnt_b++;
        if (wr_en_c) begin
            wr_cnt_c++;
            ones_c += $countones(wr_data_c);
            if (exp_c.size() == 0) check("c_unexpected_write", 64'(wr_addr_c), 64'hFFFF);
            else begin
                e = exp_c.pop_front();
                check("c_wr_addr", 64'(wr_addr_c), 64'(e.addr));
                check("c_wr_data", 64'(wr_data_c), 64'(e.data));
            end
        end
        if (random_en_c) ren_cnt_c++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          bits[$];
        int unsigned n;
        logic [15:0] lfsr;
        logic        fb;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_random_en", 64'(random_en_a), 64'd0);
        check("rst_wr_en", 64'(wr_en_a), 64'd0);
        check("rst_wr_addr", 64'(wr_addr_a), 64'd0);
        check("rst_wr_data", 64'(wr_data_c), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_c), 64'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // All-ones stream, DENSITY=1: two rows of 4'hF, done 11 cycles after start
        bits = {1, 1, 1, 1, 1, 1, 1, 1};
        src_a = bits;
        exp_a.push_back('{addr: 0, data: 32'hF});
        exp_a.push_back('{addr: 1, data: 32'hF});
        ren_cnt_a = 0; wr_cnt_a = 0; done_cnt_a = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n = 1;
        check("ones_busy_after_start", 64'(busy_a), 64'd1);
        while (!done_a && n < 100) begin @(negedge clk); n++; end
        check("ones_done_latency", 64'(n), 64'd11);
        check("ones_random_en_cycles", 64'(ren_cnt_a), 64'd8);
        @(negedge clk);
        check("ones_busy_dropped", 64'(busy_a), 64'd0);
        check("ones_write_count", 64'(wr_cnt_a), 64'd2);

        // Mixed stream, DENSITY=1
        bits = {1, 0, 1, 1, 0, 0, 1, 0};
        src_a = bits;
        exp_a.push_back('{addr: 0, data: model_row(bits, 0, 4, 1)});
        exp_a.push_back('{addr: 1, data: model_row(bits, 4, 4, 1)});
        wr_cnt_a = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n = 1;
        while (!done_a && n < 100) begin @(negedge clk); n++; end
        check("mixed_done_seen", 64'(done_a), 64'd1);
        check("mixed_write_count", 64'(wr_cnt_a), 64'd2);
        check("mixed_wr_data_held", 64'(wr_data_a), 64'h2);

        // DENSITY=2: pairs ANDed, first write after 8 SHIFT cycles
        bits = {1, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0};
        src_b = bits;
        exp_b.push_back('{addr: 0, data: model_row(bits, 0, 4, 2)});
        exp_b.push_back('{addr: 1, data: model_row(bits, 8, 4, 2)});
        ren_cnt_b = 0; wr_cnt_b = 0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        n = 1;
        while (!wr_en_b && n < 100) begin @(negedge clk); n++; end
        check("dens2_first_wr_en", 64'(n), 64'd9);
        check("dens2_row0", 64'(wr_data_b), 64'h9);
        while (!done_b && n < 100) begin @(negedge clk); n++; end
        check("dens2_done_latency", 64'(n), 64'd19);
        check("dens2_bits_consumed", 64'(ren_cnt_b), 64'd16);
        check("dens2_write_count", 64'(wr_cnt_b), 64'd2);

        // start pulsed while busy and held during DONE: a single operation only
        bits = {1, 1, 1, 1, 0, 1, 1, 0};
        src_a = bits;
        exp_a.push_back('{addr: 0, data: model_row(bits, 0, 4, 1)});
        exp_a.push_back('{addr: 1, data: model_row(bits, 4, 4, 1)});
        wr_cnt_a = 0; done_cnt_a = 0; ren_cnt_a = 0;
        @(negedge clk) start_a = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start_a = done_a ? 1'b1 : ~start_a;
        end while (!done_a && n < 100);
        @(negedge clk) start_a = 1'b0;
        check("restart_busy_idle", 64'(busy_a), 64'd0);
        repeat (20) @(negedge clk);
        check("restart_write_count", 64'(wr_cnt_a), 64'd2);
        check("restart_done_count", 64'(done_cnt_a), 64'd1);
        check("restart_bits_consumed", 64'(ren_cnt_a), 64'd8);
        check("restart_still_idle", 64'(busy_a), 64'd0);

        // Reset during row 1 SHIFT, then restart from row 0
        bits = {1, 0, 1, 0, 1, 1, 1, 1};
        src_a = bits;
        exp_a.push_back('{addr: 0, data: model_row(bits, 0, 4, 1)});
        wr_cnt_a = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n = 1;
        while (wr_cnt_a == 0 && n < 100) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("rstmid_in_shift", 64'(random_en_a), 64'd1);
        rst_b = 1'b0;
        #1;
        check("rstmid_random_en", 64'(random_en_a), 64'd0);
        check("rstmid_wr_en", 64'(wr_en_a), 64'd0);
        check("rstmid_busy", 64'(busy_a), 64'd0);
        check("rstmid_wr_data", 64'(wr_data_a), 64'd0);
        repeat (4) @(negedge clk);
        rst_b = 1'b1;
        repeat (4) @(negedge clk);
        check("rstmid_no_more_writes", 64'(wr_cnt_a), 64'd1);
        src_a.delete();
        bits = {0, 1, 1, 0, 1, 1, 1, 1};
        src_a = bits;
        exp_a.push_back('{addr: 0, data: model_row(bits, 0, 4, 1)});
        exp_a.push_back('{addr: 1, data: model_row(bits, 4, 4, 1)});
        wr_cnt_a = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n = 1;
        while (!done_a && n < 100) begin @(negedge clk); n++; end
        check("rstmid_rerun_done_latency", 64'(n), 64'd11);
        check("rstmid_rerun_writes", 64'(wr_cnt_a), 64'd2);
        check("rstmid_scoreboard_drained", 64'(exp_a.size()), 64'd0);

        // Default parameters fed by a 16-bit LFSR standing in for random_gen
        bits.delete();
        lfsr = 16'hACE1;
        for (int unsigned i = 0; i < 24 * 32 * 2; i++) begin
            bits.push_back(lfsr[0]);
            fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
            lfsr = {fb, lfsr[15:1]};
        end
        src_c = bits;
        for (int unsigned r = 0; r < 24; r++)
            exp_c.push_back('{addr: r, data: model_row(bits, r * 64, 32, 2)});
        @(negedge clk) start_c = 1'b1;
        @(negedge clk) start_c = 1'b0;
        n = 1;
        while (!done_c && n < 3000) begin @(negedge clk); n++; end
        check("dflt_done_latency", 64'(n), 64'(24 * 65 + 1));
        check("dflt_write_count", 64'(wr_cnt_c), 64'd24);
        check("dflt_bits_consumed", 64'(ren_cnt_c), 64'd1536);
        check("dflt_density_low", 64'(ones_c >= 154), 64'd1);
        check("dflt_density_high", 64'(ones_c <= 230), 64'd1);
        check("dflt_scoreboard_drained", 64'(exp_c.size()), 64'd0);
        @(negedge clk);
        check("dflt_busy_dropped", 64'(busy_c), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
